// File: rtl/halfcycle_capture_fifo_pkg.sv
// Shared capture-side definitions: the clog2 helper used for pointer and level widths.
// The capture FIFO and the later transmit-side blocks both import this package.
package halfcycle_capture_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/halfcycle_capture_fifo_ram.sv
// capture_ram: DEPTH x WIDTH storage with one posedge write port and one asynchronous read port.
// The storage has no reset; its contents only matter where level says a word is valid.
module capture_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/halfcycle_capture_fifo.sv
// Posedge receiver for words launched on the falling edge; DEPTH-entry FIFO with sticky overflow.
// Optional HALFCYCLE_DROP_COUNT_EN adds a saturating dropped-word counter and its drop_count port.
module halfcycle_capture_fifo
    import halfcycle_capture_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     src_valid,
    input  logic [WIDTH-1:0]         src_data,
    output logic                     src_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [clog2(DEPTH):0]    level,
    output logic                     overflow,
    input  logic                     ovf_clr
`ifdef HALFCYCLE_DROP_COUNT_EN
    ,
    output logic [CNT_W-1:0]         drop_count
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_check
        $error("halfcycle_capture_fifo: DEPTH must be a power of two and >= 2");
    end
    if (CNT_W < 1) begin : g_cnt_check
        $error("halfcycle_capture_fifo: CNT_W must be at least 1");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    // Flags decode only the registered level so neither ready nor valid has an input path.
    assign src_ready = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = src_valid && src_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = src_valid && !src_ready;

    capture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (src_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef HALFCYCLE_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (ovf_clr) begin
            drop_count <= drop ? CNT_W'(1) : '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_halfcycle_capture_fifo.sv
// Self-checking bench for halfcycle_capture_fifo: directed scenarios plus a randomized run
// against a queue-based reference model. Drop-count checks exist when HALFCYCLE_DROP_COUNT_EN is set.
module tb_halfcycle_capture_fifo;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             ovf_clr;
`ifdef HALFCYCLE_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_count;
`endif

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    int               m_cnt;

    halfcycle_capture_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef HALFCYCLE_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (called just after a negedge), let the posedge act, update
    // the reference model from the spec rules, and return on the following negedge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                        input logic c, input logic rs);
        int  lv;
        bit  drop;
        src_valid = v;
        src_data  = d;
        out_ready = r;
        ovf_clr   = c;
        reset     = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            lv   = m_q.size();
            drop = v && (lv == DEPTH);
            if (r && lv != 0) void'(m_q.pop_front());
            if (v && lv != DEPTH) m_q.push_back(d);
            if (drop) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (c) m_cnt = drop ? 1 : 0;
            else if (drop && m_cnt != CNT_MAX) m_cnt = m_cnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_src_ready got=%b exp=1", src_ready); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef HALFCYCLE_DROP_COUNT_EN
        n_checks++;
        if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
`endif
    endtask

    task automatic test_single_word();
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level got=%0d exp=1", level); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        n_checks++;
        if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_out_data got=%h exp=deadbeef", out_data); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pop level=%0d out_valid=%b exp=0/0", level, out_valid);
        end
    endtask

    task automatic test_fill_wrap();
        logic [WIDTH-1:0] exp_word;
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(4) || src_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full level=%0d src_ready=%b exp=4/0", level, src_ready);
        end
        exp_word = 1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (out_data !== exp_word) begin n_fail++; $display("FAIL wrap_order got=%h exp=%h", out_data, exp_word); end
            exp_word++;
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, WIDTH'(5), 1'b0, 1'b0, 1'b0);
        step(1'b1, WIDTH'(6), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_word) begin
                n_fail++; $display("FAIL wrap_order got=%h/%b exp=%h/1", out_data, out_valid, exp_word);
            end
            exp_word++;
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (level !== '0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL wrap_end level=%0d overflow=%b exp=0/0", level, overflow);
        end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + WIDTH'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(3)) begin n_fail++; $display("FAIL fullsim_level got=%0d exp=3", level); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL fullsim_overflow got=%b exp=1", overflow); end
        n_checks++;
        if (out_data !== 32'hA1) begin n_fail++; $display("FAIL fullsim_head got=%h exp=a1", out_data); end
`ifdef HALFCYCLE_DROP_COUNT_EN
        n_checks++;
        if (drop_count !== CNT_W'(1)) begin n_fail++; $display("FAIL fullsim_drop_count got=%0d exp=1", drop_count); end
`endif
    endtask

    task automatic test_clear_race();
        step(1'b1, 32'hA4, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hBAD1_0000, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL race_overflow got=%b exp=1", overflow); end
`ifdef HALFCYCLE_DROP_COUNT_EN
        n_checks++;
        if (drop_count !== CNT_W'(1)) begin n_fail++; $display("FAIL race_drop_count got=%0d exp=1", drop_count); end
`endif
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
`ifdef HALFCYCLE_DROP_COUNT_EN
        n_checks++;
        if (drop_count !== '0) begin n_fail++; $display("FAIL clr_drop_count got=%0d exp=0", drop_count); end
`endif
    endtask

    task automatic test_midstream_reset();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(3)) begin n_fail++; $display("FAIL midrst_setup_level got=%0d exp=3", level); end
        step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (level !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst level=%0d out_valid=%b exp=0/0", level, out_valid);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_nothing_accepted level=%0d out_valid=%b exp=0/0", level, out_valid);
        end
    endtask

`ifdef HALFCYCLE_DROP_COUNT_EN
    task automatic test_saturation();
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 5; i++) step(1'b1, 32'hEEEE, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (drop_count !== CNT_W'(CNT_MAX)) begin
            n_fail++; $display("FAIL saturation got=%0d exp=%0d", drop_count, CNT_MAX);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        logic v, r, c, rs;
        for (int cyc = 0; cyc < 600; cyc++) begin
            v  = ($urandom_range(0, 99) < 70);
            r  = ($urandom_range(0, 99) < ((cyc / 100) % 2 == 0 ? 30 : 80));
            c  = ($urandom_range(0, 99) < 8);
            rs = ($urandom_range(0, 199) == 0);
            step(v, WIDTH'($urandom), r, c, rs);
            n_checks++;
            if (level !== LW'(m_q.size())) begin
                n_fail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, level, m_q.size());
            end
            n_checks++;
            if (out_valid !== (m_q.size() != 0) || src_ready !== (m_q.size() != DEPTH)) begin
                n_fail++; $display("FAIL rand_flags cyc=%0d valid=%b ready=%b exp_level=%0d", cyc, out_valid, src_ready, m_q.size());
            end
            if (m_q.size() != 0) begin
                n_checks++;
                if (out_data !== m_q[0]) begin
                    n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, m_q[0]);
                end
            end
            n_checks++;
            if (overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
            end
`ifdef HALFCYCLE_DROP_COUNT_EN
            n_checks++;
            if (drop_count !== CNT_W'(m_cnt)) begin
                n_fail++; $display("FAIL rand_drop_count cyc=%0d got=%0d exp=%0d", cyc, drop_count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_ovf     = 0;
        m_cnt     = 0;
        reset     = 1'b1;
        src_valid = 1'b0;
        src_data  = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_fill_wrap();
        test_full_simultaneous();
        test_clear_race();
        test_midstream_reset();
`ifdef HALFCYCLE_DROP_COUNT_EN
        test_saturation();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
